// File: rtl/act_c2_demux_if.sv
// act_c2_demux_if: bundle of the routing input port, the select lines and the
// four output channels (data, valid, ready, accept counters) of act_c2_demux.
//   in_data/in_valid/in_ready : producer handshake
//   A1, B1, A0, B0            : C2-style select lines, sampled with in_data
//   Qxx/Vxx/Rxx               : per-channel data, valid, consumer ready
//   Cxx                       : per-channel accepted-word counters
// Modports: slave = the demux itself, master = producer + consumers.
interface act_c2_demux_if #(
  parameter int unsigned bits = 2
) ();
  localparam int unsigned cnt_w = 8;

  logic [bits-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic             A1, B1, A0, B0;
  logic [bits-1:0]  Q00, Q01, Q10, Q11;
  logic             V00, V01, V10, V11;
  logic             R00, R01, R10, R11;
  logic [cnt_w-1:0] C00, C01, C10, C11;

  modport slave (
    input  in_data, in_valid, A1, B1, A0, B0, R00, R01, R10, R11,
    output in_ready, Q00, Q01, Q10, Q11, V00, V01, V10, V11,
           C00, C01, C10, C11
  );

  modport master (
    output in_data, in_valid, A1, B1, A0, B0, R00, R01, R10, R11,
    input  in_ready, Q00, Q01, Q10, Q11, V00, V01, V10, V11,
           C00, C01, C10, C11
  );
endinterface

// File: rtl/act_c2_demux.sv
// act_c2_demux: registered 1-to-4 demultiplexer, the inverse of the ACT C2 mux.
// A word is steered to channel {S0,S1} with S0 = A0 & B0, S1 = A1 | B1. Each
// channel is a one-entry register with valid/ready handshake.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (priority over all activity)
//   bus  : act_c2_demux_if.slave (input handshake, selects, channel outputs)
// Optional feature: define ACT_C2_DEMUX_STATS_EN to build the saturating
// per-channel accept counters Cxx; otherwise Cxx are tied to 0.
module act_c2_demux #(
  parameter int unsigned bits = 2
) (
  input  logic          clk,
  input  logic          rst,
  act_c2_demux_if.slave bus
);
  localparam int unsigned n_ch  = 4;
  localparam int unsigned sel_w = 2;
  localparam int unsigned cnt_w = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_t;

  ch_state_t        state     [n_ch];
  ch_state_t        state_nxt [n_ch];
  logic [bits-1:0]  q         [n_ch];
  logic [sel_w-1:0] sel;
  logic [n_ch-1:0]  r;
  logic             ready_c;
  logic             accept_c;

  // C2 select decode and ready/accept; ready ignores in_valid by design
  always_comb begin
    sel      = {bus.A0 & bus.B0, bus.A1 | bus.B1};
    r        = {bus.R11, bus.R10, bus.R01, bus.R00};
    ready_c  = (state[sel] == EMPTY) | r[sel];
    accept_c = bus.in_valid & ready_c;
  end

  assign bus.in_ready = ready_c;

  // Per-channel next state: an accept wins over a drain in the same cycle
  always_comb begin
    for (int i = 0; i < n_ch; i++) begin
      state_nxt[i] = state[i];
      if (accept_c && (sel == sel_w'(i))) begin
        state_nxt[i] = FULL;
      end else if (r[i]) begin
        state_nxt[i] = EMPTY;
      end
    end
  end

  // Channel state and data registers; data holds after the word is drained
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < n_ch; i++) begin
        state[i] <= EMPTY;
        q[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < n_ch; i++) begin
        state[i] <= state_nxt[i];
        if (accept_c && (sel == sel_w'(i))) begin
          q[i] <= bus.in_data;
        end
      end
    end
  end

  assign bus.Q00 = q[0];
  assign bus.Q01 = q[1];
  assign bus.Q10 = q[2];
  assign bus.Q11 = q[3];
  assign bus.V00 = (state[0] == FULL);
  assign bus.V01 = (state[1] == FULL);
  assign bus.V10 = (state[2] == FULL);
  assign bus.V11 = (state[3] == FULL);

`ifdef ACT_C2_DEMUX_STATS_EN
  localparam logic [cnt_w-1:0] cnt_max = '1;

  logic [cnt_w-1:0] cnt [n_ch];

  // Saturating accept counters, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < n_ch; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < n_ch; i++) begin
        if (accept_c && (sel == sel_w'(i)) && (cnt[i] != cnt_max)) begin
          cnt[i] <= cnt[i] + cnt_w'(1);
        end
      end
    end
  end

  assign bus.C00 = cnt[0];
  assign bus.C01 = cnt[1];
  assign bus.C10 = cnt[2];
  assign bus.C11 = cnt[3];
`else
  assign bus.C00 = '0;
  assign bus.C01 = '0;
  assign bus.C10 = '0;
  assign bus.C11 = '0;
`endif
endmodule

// File: doc/act_c2_demux.md
# act_c2_demux

Registered 1-to-4 demultiplexer and the inverse of the ACT C2 cell mux. An input word is steered to one of four output channels using the same select decode as the C2 cell: S0 = A0 & B0, S1 = A1 | B1. Each channel has a one-entry output register with a valid/ready handshake. The block feeds C2-mapped datapaths in the CA2 design, where a producer must route data to the leg a C2 mux would pick.

## Interface
- bits, default 2: data width of input and every output channel.
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  bits  word to route.
- in_valid  input  1  in_data and the select lines are valid.
- in_ready  output  1  block accepts the word this cycle.
- A1, B1, A0, B0  input  1 each  select lines; decoded as in C2, sampled with in_data.
- Q00, Q01, Q10, Q11  output  bits each  channel data registers.
- V00, V01, V10, V11  output  1 each  channel holds an unconsumed word.
- R00, R01, R10, R11  input  1 each  consumer ready per channel.
- C00, C01, C10, C11  output  8 each  per-channel accepted-word counters (see Configuration).

## Operation
- Decode: S0 = A0 & B0, S1 = A1 | B1. Channel index {S0,S1}: 00→Q00, 01→Q01, 10→Q10, 11→Q11.
- Channel register state per channel: EMPTY (Vxx=0) or FULL (Vxx=1).
- Transitions:
  - EMPTY→FULL on accept to that channel.
  - FULL→EMPTY when Rxx=1 and no new accept to it in the same cycle.
  - FULL→FULL with new data when Rxx=1 and an accept to it occurs in the same cycle.
- in_ready = !Vsel | Rsel, where sel is the decoded channel. in_ready is combinational from the select lines, Vxx and Rxx. It never depends on in_valid.
- Accept = in_valid & in_ready. On accept, Qsel <= in_data and Vsel <= 1. Non-selected channels are unaffected.
- Held data: Qxx is stable while Vxx=1 and Rxx=0. Qxx keeps its last value after the word is consumed.
- Channels drain independently. Each Rxx affects only its own channel. Any number of channels may drain in one cycle.
- At most one accept per cycle.
- Select lines are don't-care when in_valid=0.
- Reset: all Vxx=0, all Qxx=0, all Cxx=0. in_ready is therefore 1 after reset. Reset mid-operation discards held words without a handshake.

## Timing
- Latency: a word accepted at edge N appears on Qsel with Vsel=1 after edge N. That is one cycle, with no combinational path from in_data to Qxx.
- Throughput: one word per cycle to a single channel when its Rxx is held at 1. In that case in_ready stays 1 and each accept replaces the word as it is consumed.
- Backpressure: if the selected channel is FULL with Rxx=0, in_ready=0. The producer must hold in_data and the select lines until acceptance. Switching select to an EMPTY channel is legal and may be accepted immediately.
- rst has priority over every accept, drain and count in the same cycle.

## Configuration
- ACT_C2_DEMUX_STATS_EN defined:
  - Cxx increments by 1 on every accept to channel xx.
  - Counters saturate at 255 and hold there.
  - Counters clear only on rst.
- Not defined: the counter logic is not compiled, and C00..C11 are tied to 0. Routing behaviour is identical in both builds.

## Test plan
- Reset then route: rst 1 cycle, then in_data=2'b10 with A0=B0=1, A1=B1=0, R10=0 → next cycle V10=1, Q10=2'b10, other Vxx=0, C10=1 (stats build).
- Backpressure: with V10=1 and R10=0, present a second word to select 10 → in_ready=0 and Q10 unchanged. Raise R10 → word accepted, Q10 updated the next cycle with V10 still 1.
- Simultaneous drain and load: with V01=1 and R01=1, accept 2'b11 on A1=1, A0=0 → Q01=2'b11 and V01=1 the next cycle, no bubble.
- Channel independence: fill all four channels with 0,1,2,3 using selects 00, 01, 10, 11, with every Rxx=0 → each Qxx holds its own value. Raise only R11 → only V11 clears.
- Reset mid-operation: all channels FULL, assert rst with in_valid=1 → next cycle every Vxx=0, Qxx=0 and Cxx=0, and nothing is accepted.
- Stats saturation (ACT_C2_DEMUX_STATS_EN): send 300 words to select 00 with R00=1 → C00=255, other counters 0. In a build without the macro, all Cxx stay 0.
